// File: rtl/rram_vddh_sequencer_pkg.sv
// Shared types, default phase lengths and strobe decode for the VDDH RRAM sequencer.
package rram_vddh_sequencer_pkg;

  localparam int unsigned PRE_CYC_DEF  = 2;
  localparam int unsigned DVLP_CYC_DEF = 4;
  localparam int unsigned SA_CYC_DEF   = 2;
  localparam int unsigned WR_CYC_DEF   = 8;
  localparam int unsigned CNT_W_DEF    = 4;
  localparam int unsigned DW_DEF       = 8;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_PRE   = 3'd1,
    ST_DVLP  = 3'd2,
    ST_SENSE = 3'd3,
    ST_WRITE = 3'd4,
    ST_DONE  = 3'd5
  } state_t;

  // Control outputs of the sequencer, registered together.
  typedef struct packed {
    logic write_vddh;
    logic read_vddh;
    logic pre_h;
    logic dvlp_h;
    logic sa_en_h;
    logic dummy_en;
    logic done;
    logic req_ready;
  } strobe_t;

  // Decode the strobe set that belongs to a given state.
  function automatic strobe_t decode_strobes(input state_t st);
    strobe_t s;
    s            = '0;
    s.write_vddh = (st == ST_WRITE);
    s.read_vddh  = (st == ST_PRE) || (st == ST_DVLP) || (st == ST_SENSE);
    s.pre_h      = (st == ST_PRE);
    s.dvlp_h     = (st == ST_DVLP);
    s.sa_en_h    = (st == ST_SENSE);
    s.dummy_en   = s.read_vddh;
    s.done       = (st == ST_DONE);
    s.req_ready  = (st == ST_IDLE);
    return s;
  endfunction

endpackage

// File: rtl/rram_phase_counter.sv
// Loadable down-counter timing each sequencer phase; saturates at zero.
module rram_phase_counter
  import rram_vddh_sequencer_pkg::*;
#(
  parameter int unsigned CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             zero_c
);

  logic [CNT_W-1:0] count;

  // Load on phase entry, otherwise count down to zero and hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (count != '0) begin
      count <= count - CNT_W'(1);
    end
  end

  assign zero_c = (count == '0);

endmodule

// File: rtl/rram_vddh_sequencer.sv
// VDDH-domain RRAM strobe sequencer: one read or write at a time, fixed phase timing.
module rram_vddh_sequencer
  import rram_vddh_sequencer_pkg::*;
#(
  parameter int unsigned PRE_CYC  = PRE_CYC_DEF,
  parameter int unsigned DVLP_CYC = DVLP_CYC_DEF,
  parameter int unsigned SA_CYC   = SA_CYC_DEF,
  parameter int unsigned WR_CYC   = WR_CYC_DEF,
  parameter int unsigned CNT_W    = CNT_W_DEF,
  parameter int unsigned DW       = DW_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req_valid,
  input  logic          req_write,
  output logic          req_ready,
  input  logic [DW-1:0] sa_out,
  output logic [DW-1:0] rd_data,
  output logic          done,
  output logic          write_vddh,
  output logic          read_vddh,
  output logic          pre_h,
  output logic          dvlp_h,
  output logic          sa_en_h,
  output logic          dummy_en
);

  state_t           state;
  state_t           next_state;
  strobe_t          strobes_q;
  logic             accept_c;
  logic             capture_c;
  logic             cnt_load_c;
  logic [CNT_W-1:0] cnt_load_val_c;
  logic             cnt_zero_c;

  rram_phase_counter #(
    .CNT_W(CNT_W)
  ) u_phase_counter (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (cnt_load_c),
    .load_val(cnt_load_val_c),
    .zero_c  (cnt_zero_c)
  );

  // Next-state and phase-counter load decode.
  always_comb begin
    next_state     = state;
    cnt_load_c     = 1'b0;
    cnt_load_val_c = '0;
    accept_c       = req_valid && strobes_q.req_ready && (state == ST_IDLE);
    unique case (state)
      ST_IDLE: begin
        if (accept_c) begin
          cnt_load_c = 1'b1;
          if (req_write) begin
            next_state     = ST_WRITE;
            cnt_load_val_c = CNT_W'(WR_CYC - 1);
          end else begin
            next_state     = ST_PRE;
            cnt_load_val_c = CNT_W'(PRE_CYC - 1);
          end
        end
      end
      ST_PRE: begin
        if (cnt_zero_c) begin
          next_state     = ST_DVLP;
          cnt_load_c     = 1'b1;
          cnt_load_val_c = CNT_W'(DVLP_CYC - 1);
        end
      end
      ST_DVLP: begin
        if (cnt_zero_c) begin
          next_state     = ST_SENSE;
          cnt_load_c     = 1'b1;
          cnt_load_val_c = CNT_W'(SA_CYC - 1);
        end
      end
      ST_SENSE: begin
        if (cnt_zero_c) next_state = ST_DONE;
      end
      ST_WRITE: begin
        if (cnt_zero_c) next_state = ST_DONE;
      end
      ST_DONE: begin
        next_state = ST_IDLE;
      end
      default: begin
        next_state = ST_IDLE;
      end
    endcase
  end

  // Sense data is sampled on the final SENSE cycle.
  assign capture_c = (state == ST_SENSE) && cnt_zero_c;

  // State, registered strobes (decoded from next state) and read data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      strobes_q <= '0;
      rd_data   <= '0;
    end else begin
      state     <= next_state;
      strobes_q <= decode_strobes(next_state);
      if (capture_c) rd_data <= sa_out;
    end
  end

  assign write_vddh = strobes_q.write_vddh;
  assign read_vddh  = strobes_q.read_vddh;
  assign pre_h      = strobes_q.pre_h;
  assign dvlp_h     = strobes_q.dvlp_h;
  assign sa_en_h    = strobes_q.sa_en_h;
  assign dummy_en   = strobes_q.dummy_en;
  assign done       = strobes_q.done;
  assign req_ready  = strobes_q.req_ready;

endmodule

// File: tb/tb_rram_vddh_sequencer.sv
// Self-checking bench: default-timing DUT (a_*) and all-phases-one-cycle DUT (b_*).
module tb_rram_vddh_sequencer;

  localparam int P = 2;
  localparam int D = 4;
  localparam int S = 2;
  localparam int W = 8;
  localparam logic [7:0] IDLE_VEC = 8'b0000_0001;

  logic       clk;
  logic       rst_n;
  logic       req_valid;
  logic       req_write;
  logic [7:0] sa_out;

  logic       a_req_ready, a_done, a_write_vddh, a_read_vddh, a_pre_h, a_dvlp_h, a_sa_en_h, a_dummy_en;
  logic [7:0] a_rd_data;
  logic       b_req_ready, b_done, b_write_vddh, b_read_vddh, b_pre_h, b_dvlp_h, b_sa_en_h, b_dummy_en;
  logic [7:0] b_rd_data;

  int         checks;
  int         failures;
  logic [7:0] exp_q[$];
  logic [7:0] rd_model[2];

  rram_vddh_sequencer dut_a (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_write(req_write),
    .req_ready(a_req_ready), .sa_out(sa_out), .rd_data(a_rd_data), .done(a_done),
    .write_vddh(a_write_vddh), .read_vddh(a_read_vddh), .pre_h(a_pre_h),
    .dvlp_h(a_dvlp_h), .sa_en_h(a_sa_en_h), .dummy_en(a_dummy_en)
  );

  rram_vddh_sequencer #(
    .PRE_CYC(1), .DVLP_CYC(1), .SA_CYC(1), .WR_CYC(1), .CNT_W(4), .DW(8)
  ) dut_b (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_write(req_write),
    .req_ready(b_req_ready), .sa_out(sa_out), .rd_data(b_rd_data), .done(b_done),
    .write_vddh(b_write_vddh), .read_vddh(b_read_vddh), .pre_h(b_pre_h),
    .dvlp_h(b_dvlp_h), .sa_en_h(b_sa_en_h), .dummy_en(b_dummy_en)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Observed vector: {write, read, pre, dvlp, sa_en, dummy, done, ready}
  function automatic logic [7:0] obs(input bit sel);
    if (sel) return {b_write_vddh, b_read_vddh, b_pre_h, b_dvlp_h, b_sa_en_h, b_dummy_en, b_done, b_req_ready};
    return {a_write_vddh, a_read_vddh, a_pre_h, a_dvlp_h, a_sa_en_h, a_dummy_en, a_done, a_req_ready};
  endfunction

  function automatic logic [7:0] rd(input bit sel);
    return sel ? b_rd_data : a_rd_data;
  endfunction

  // Expected vector k cycles after the accepting edge.
  function automatic logic [7:0] exp_vec(input bit wr, input int k, input int p, input int d,
                                         input int s, input int w);
    logic wv, rv, pr, dv, se, dn;
    if (wr) begin
      wv = (k >= 1) && (k <= w);
      rv = 1'b0; pr = 1'b0; dv = 1'b0; se = 1'b0;
      dn = (k == w + 1);
    end else begin
      wv = 1'b0;
      pr = (k >= 1) && (k <= p);
      dv = (k > p) && (k <= p + d);
      se = (k > p + d) && (k <= p + d + s);
      rv = (k >= 1) && (k <= p + d + s);
      dn = (k == p + d + s + 1);
    end
    return {wv, rv, pr, dv, se, rv, dn, 1'b0};
  endfunction

  task automatic check_done_data(input bit sel, input string tag);
    logic [7:0] e;
    checks++;
    if (exp_q.size() == 0) begin
      failures++;
      $display("FAIL %s scoreboard_empty act_rd=%h", tag, rd(sel));
    end else begin
      e = exp_q.pop_front();
      if (rd(sel) !== e) begin
        failures++;
        $display("FAIL %s rd_data act=%h exp=%h", tag, rd(sel), e);
      end
    end
  endtask

  task automatic do_reset;
    rst_n = 1'b0;
    req_valid = 1'b0;
    exp_q.delete();
    rd_model[0] = 8'h00;
    rd_model[1] = 8'h00;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  // One operation from an IDLE cycle; returns positioned in the following IDLE cycle.
  task automatic run_op(input bit sel, input bit wr, input logic [7:0] sa, input int p, input int d,
                        input int s, input int w, input string tag);
    int len;
    logic [7:0] e, o;
    len = wr ? w + 1 : p + d + s + 1;
    o = obs(sel);
    checks++;
    if (o !== IDLE_VEC) begin
      failures++;
      $display("FAIL %s idle_before act=%b exp=%b", tag, o, IDLE_VEC);
    end
    req_valid = 1'b1;
    req_write = wr;
    sa_out = sa;
    exp_q.push_back(wr ? rd_model[sel] : sa);
    if (!wr) rd_model[sel] = sa;
    @(posedge clk); #1;
    req_valid = 1'b0;
    for (int k = 1; k <= len; k++) begin
      e = exp_vec(wr, k, p, d, s, w);
      o = obs(sel);
      checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL %s cycle%0d strobes act=%b exp=%b", tag, k, o, e);
      end
      if (e[1]) check_done_data(sel, tag);
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset;
    logic [7:0] o;
    rst_n = 1'b0;
    req_valid = 1'b1;
    req_write = 1'b0;
    sa_out = 8'h00;
    rd_model[0] = 8'h00;
    rd_model[1] = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    o = obs(0);
    checks++;
    if (o !== 8'h00 || a_rd_data !== 8'h00) begin
      failures++;
      $display("FAIL reset_hold_a act=%b rd=%h exp=%b rd=00", o, a_rd_data, 8'h00);
    end
    o = obs(1);
    checks++;
    if (o !== 8'h00 || b_rd_data !== 8'h00) begin
      failures++;
      $display("FAIL reset_hold_b act=%b rd=%h exp=%b rd=00", o, b_rd_data, 8'h00);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    o = obs(0);
    checks++;
    if (o !== IDLE_VEC) begin
      failures++;
      $display("FAIL reset_release act=%b exp=%b", o, IDLE_VEC);
    end
    req_valid = 1'b0;
    @(posedge clk); #1;
    o = obs(0);
    checks++;
    if (o !== IDLE_VEC) begin
      failures++;
      $display("FAIL reset_no_accept act=%b exp=%b", o, IDLE_VEC);
    end
  endtask

  task automatic test_read;
    run_op(0, 1'b0, 8'hA5, P, D, S, W, "read_default");
  endtask

  task automatic test_write;
    run_op(0, 1'b1, 8'h3C, P, D, S, W, "write_default");
    checks++;
    if (a_rd_data !== 8'hA5) begin
      failures++;
      $display("FAIL write_keeps_rd act=%h exp=%h", a_rd_data, 8'hA5);
    end
  endtask

  // REQ_VALID held high, alternating direction: one accept per IDLE, 10 cycles per op.
  task automatic test_back_to_back;
    logic [7:0] e, o;
    int len;
    bit wr;
    req_valid = 1'b1;
    req_write = 1'b0;
    sa_out = 8'h11;
    for (int op = 0; op < 4; op++) begin
      wr = req_write;
      len = wr ? W + 1 : P + D + S + 1;
      exp_q.push_back(wr ? rd_model[0] : sa_out);
      if (!wr) rd_model[0] = sa_out;
      @(posedge clk); #1;
      for (int k = 1; k <= len; k++) begin
        e = exp_vec(wr, k, P, D, S, W);
        o = obs(0);
        checks++;
        if (o !== e) begin
          failures++;
          $display("FAIL b2b op%0d cycle%0d act=%b exp=%b", op, k, o, e);
        end
        checks++;
        if ($countones({o[7], o[5], o[4], o[3]}) > 1 || (o[7] && o[6])) begin
          failures++;
          $display("FAIL b2b_exclusive op%0d cycle%0d act=%b exp=at_most_one", op, k, o);
        end
        if (e[1]) check_done_data(0, "b2b");
        @(posedge clk); #1;
      end
      o = obs(0);
      checks++;
      if (o !== IDLE_VEC) begin
        failures++;
        $display("FAIL b2b_idle op%0d act=%b exp=%b", op, o, IDLE_VEC);
      end
      req_write = ~wr;
      sa_out = sa_out + 8'h22;
      if (op == 3) req_valid = 1'b0;
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_op;
    logic [7:0] o;
    req_valid = 1'b1;
    req_write = 1'b0;
    sa_out = 8'h5A;
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (a_dvlp_h !== 1'b1) begin
      failures++;
      $display("FAIL midrst_in_dvlp act=%b exp=1", a_dvlp_h);
    end
    #2 rst_n = 1'b0;
    #1;
    o = obs(0);
    checks++;
    if (o !== 8'h00 || a_rd_data !== 8'h00) begin
      failures++;
      $display("FAIL midrst_async act=%b rd=%h exp=%b rd=00", o, a_rd_data, 8'h00);
    end
    exp_q.delete();
    rd_model[0] = 8'h00;
    rd_model[1] = 8'h00;
    @(posedge clk); #1 rst_n = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      o = obs(0);
      checks++;
      if (o !== IDLE_VEC) begin
        failures++;
        $display("FAIL midrst_no_done cycle%0d act=%b exp=%b", k, o, IDLE_VEC);
      end
    end
    run_op(0, 1'b0, 8'hC3, P, D, S, W, "read_after_rst");
  endtask

  task automatic test_min_phases;
    do_reset();
    run_op(1, 1'b0, 8'h96, 1, 1, 1, 1, "min_read");
    run_op(1, 1'b1, 8'h0F, 1, 1, 1, 1, "min_write");
    checks++;
    if (b_rd_data !== 8'h96) begin
      failures++;
      $display("FAIL min_write_keeps_rd act=%h exp=%h", b_rd_data, 8'h96);
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_read();
    test_write();
    test_back_to_back();
    test_reset_mid_op();
    test_min_phases();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
